// File: rtl/nf10_upb_pktgen_pkg.sv
// Shared types and helpers for the UPB AXI4-Stream packet generator.
// Contents: FSM state enum, LFSR constants, tkeep and port-rotation helpers.
// No ports; combinational helpers only. Backpressure is not applicable.
package nf10_upb_pktgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } pktgen_state_t;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [15:0] LFSR_SEED_LO = 16'hACE1;

  // Widest supported stream is 512 bits, so 64 byte enables.
  localparam int MAX_KEEP = 64;

  // Byte enables for the last beat of a packet of 'len' bytes on a stream
  // 'bytes' wide. A length that fills the last beat exactly gives all ones.
  function automatic logic [MAX_KEEP-1:0] keep_from_len(input logic [31:0] len,
                                                        input int          bytes);
    logic [31:0]         rem;
    logic [MAX_KEEP-1:0] keep;
    rem  = len % 32'(bytes);
    keep = '0;
    for (int i = 0; i < MAX_KEEP; i++) begin
      keep[i] = (rem == 32'd0) ? (i < bytes) : (32'(i) < rem);
    end
    return keep;
  endfunction

  // Next set bit of 'mask' after 'port', wrapping over 'nports' ports.
  // Returns 'port' itself when it is the only set bit.
  function automatic logic [2:0] next_port(input logic [2:0] port,
                                           input logic [7:0] mask,
                                           input int         nports);
    logic [2:0] res;
    logic       found;
    int         idx;
    res   = port;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(port) + k) % nports;
      if (!found && (k <= nports) && mask[idx[2:0]]) begin
        res   = idx[2:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nf10_upb_pktgen_lfsr.sv
// Parallel multi-lane step of a 32-bit Galois LFSR: lane i holds the state
// after i+1 steps from 'seed'; 'next_state' is the state after the last lane.
// Ports: seed in, lanes out (32 bits per lane), next_state out. Purely combinational.
module nf10_upb_pktgen_lfsr
  import nf10_upb_pktgen_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [31:0]         seed,
  output logic [32*LANES-1:0] lanes,
  output logic [31:0]         next_state
);

  logic [31:0] s;

  always_comb begin
    s     = seed;
    lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      s = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
      lanes[32*i +: 32] = s;
    end
    next_state = s;
  end

endmodule

// File: rtl/nf10_upb_axis_pkt_gen.sv
// AXI4-Stream packet generator: round-robin over cfg_port_mask, fixed or
// sweeping lengths, self-describing payload (LFSR payload when UPB_PKTGEN_LFSR_EN
// is defined). Latency: start -> LOAD next cycle -> tvalid the cycle after.
// Backpressure: outputs held stable while tvalid && !tready; packets never truncated.
// Ports: clk/reset (sync, active high), start/stop control, cfg_* sampled at LOAD,
// m_axis_* master stream with tuser_in_port/tuser_packet_length, busy/done/pkt_count status.
module nf10_upb_axis_pkt_gen
  import nf10_upb_pktgen_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 14,
  parameter int NUM_PORTS  = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_WIDTH-1:0]    cfg_num_packets,
  input  logic [LEN_WIDTH-1:0]    cfg_len_min,
  input  logic [LEN_WIDTH-1:0]    cfg_len_max,
  input  logic [LEN_WIDTH-1:0]    cfg_len_step,
  input  logic                    cfg_sweep,
  input  logic [NUM_PORTS-1:0]    cfg_port_mask,
  input  logic [7:0]              cfg_gap,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [2:0]              m_axis_tuser_in_port,
  output logic [LEN_WIDTH-1:0]    m_axis_tuser_packet_length,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_count
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANES  = DATA_WIDTH / 32;
  localparam int LW1    = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH:0] BYTES_W  = LW1'(BYTES);
  localparam logic [LEN_WIDTH:0] BYTES_M1 = LW1'(BYTES - 1);

  pktgen_state_t           state;
  logic [2:0]              port;
  logic [CNT_WIDTH-1:0]    seq;
  logic [CNT_WIDTH-1:0]    num_lat;
  logic [LEN_WIDTH-1:0]    cur_len;
  logic [LEN_WIDTH-1:0]    sweep_len;
  logic [LEN_WIDTH-1:0]    len_min_lat;
  logic [LEN_WIDTH-1:0]    len_max_lat;
  logic [LEN_WIDTH-1:0]    len_step_lat;
  logic [LEN_WIDTH-1:0]    beats;
  logic [LEN_WIDTH-1:0]    beat_idx;
  logic [NUM_PORTS-1:0]    mask_lat;
  logic [7:0]              gap_lat;
  logic [7:0]              gap_cnt;

  logic [7:0]              mask8_cfg;
  logic [7:0]              mask8_lat;
  logic [2:0]              first_port;
  logic [LEN_WIDTH-1:0]    len_raw;
  logic [LEN_WIDTH-1:0]    len_eff;
  logic [LEN_WIDTH:0]      beats_calc;
  logic [LEN_WIDTH:0]      len_sum;
  logic [LEN_WIDTH-1:0]    len_next;
  logic [BYTES-1:0]        keep_load;
  logic [BYTES-1:0]        keep_last;
  logic [LEN_WIDTH-1:0]    next_beat;
  logic                    next_is_last;
  logic [CNT_WIDTH-1:0]    pkt_count_inc;
  logic                    finish;
  logic [DATA_WIDTH-1:0]   data_load;
  logic [DATA_WIDTH-1:0]   data_next;

  assign busy = (state == ST_LOAD) || (state == ST_SEND) || (state == ST_GAP);
  assign done = (state == ST_DONE);

  always_comb begin
    mask8_cfg = '0;
    mask8_lat = '0;
    mask8_cfg[NUM_PORTS-1:0] = cfg_port_mask;
    mask8_lat[NUM_PORTS-1:0] = mask_lat;
  end

  // Searching forward from the highest port wraps round to the lowest set bit.
  assign first_port = next_port(3'(NUM_PORTS - 1), mask8_cfg, NUM_PORTS);

  // sweep_len is zero only right after start (or when min itself is 0), and
  // in both cases the packet length is cfg_len_min.
  always_comb begin
    len_raw = (cfg_sweep && (sweep_len != '0)) ? sweep_len : cfg_len_min;
    len_eff = (len_raw > cfg_len_max) ? cfg_len_max : len_raw;
    if (len_eff == '0) len_eff = LEN_WIDTH'(1);
    beats_calc = ({1'b0, len_eff} + BYTES_M1) / BYTES_W;
  end

  // Next sweep length, restarting at min on overflow, past max, or zero step.
  always_comb begin
    len_sum = {1'b0, cur_len} + {1'b0, len_step_lat};
    if ((len_step_lat == '0) || len_sum[LEN_WIDTH] || (len_sum[LEN_WIDTH-1:0] > len_max_lat))
      len_next = len_min_lat;
    else
      len_next = len_sum[LEN_WIDTH-1:0];
  end

  assign keep_load     = BYTES'(keep_from_len(32'(len_eff), BYTES));
  assign keep_last     = BYTES'(keep_from_len(32'(cur_len), BYTES));
  assign next_beat     = beat_idx + LEN_WIDTH'(1);
  assign next_is_last  = (next_beat == beats - LEN_WIDTH'(1));
  assign pkt_count_inc = pkt_count + CNT_WIDTH'(1);
  assign finish        = ((num_lat != '0) && (pkt_count_inc == num_lat)) || stop;

`ifdef UPB_PKTGEN_LFSR_EN
  logic [31:0] lfsr_state;
  logic [31:0] lfsr_in;
  logic [31:0] lfsr_next;
  logic [DATA_WIDTH-1:0] lfsr_lanes;

  assign lfsr_in = (state == ST_LOAD) ? {16'(seq), LFSR_SEED_LO} : lfsr_state;

  nf10_upb_pktgen_lfsr #(.LANES(LANES)) u_lfsr (
    .seed       (lfsr_in),
    .lanes      (lfsr_lanes),
    .next_state (lfsr_next)
  );

  assign data_load = lfsr_lanes;
  assign data_next = lfsr_lanes;

  // Steps only when a beat is produced, so stalled data stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_state <= '0;
    end else if ((state == ST_LOAD) ||
                 ((state == ST_SEND) && m_axis_tready && !m_axis_tlast)) begin
      lfsr_state <= lfsr_next;
    end
  end
`else
  function automatic logic [DATA_WIDTH-1:0] lane_pattern(input logic [15:0]          s,
                                                         input logic [LEN_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      d[32*i +: 32] = {s, 12'(b), 4'(i)};
    end
    return d;
  endfunction

  assign data_load = lane_pattern(16'(seq), '0);
  assign data_next = lane_pattern(16'(seq), next_beat);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                      <= ST_IDLE;
      port                       <= '0;
      seq                        <= '0;
      num_lat                    <= '0;
      cur_len                    <= '0;
      sweep_len                  <= '0;
      len_min_lat                <= '0;
      len_max_lat                <= '0;
      len_step_lat               <= '0;
      beats                      <= '0;
      beat_idx                   <= '0;
      mask_lat                   <= '0;
      gap_lat                    <= '0;
      gap_cnt                    <= '0;
      pkt_count                  <= '0;
      m_axis_tdata               <= '0;
      m_axis_tkeep               <= '0;
      m_axis_tvalid              <= 1'b0;
      m_axis_tlast               <= 1'b0;
      m_axis_tuser_in_port       <= '0;
      m_axis_tuser_packet_length <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && (cfg_port_mask != '0)) begin
            state     <= ST_LOAD;
            pkt_count <= '0;
            seq       <= '0;
            sweep_len <= '0;
            port      <= first_port;
          end
        end

        ST_LOAD: begin
          cur_len                    <= len_eff;
          beats                      <= beats_calc[LEN_WIDTH-1:0];
          beat_idx                   <= '0;
          num_lat                    <= cfg_num_packets;
          len_min_lat                <= cfg_len_min;
          len_max_lat                <= cfg_len_max;
          len_step_lat               <= cfg_len_step;
          mask_lat                   <= cfg_port_mask;
          gap_lat                    <= cfg_gap;
          m_axis_tvalid              <= 1'b1;
          m_axis_tdata               <= data_load;
          m_axis_tlast               <= (beats_calc == LW1'(1));
          m_axis_tkeep               <= (beats_calc == LW1'(1)) ? keep_load : '1;
          m_axis_tuser_in_port       <= port;
          m_axis_tuser_packet_length <= len_eff;
          state                      <= ST_SEND;
        end

        ST_SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              pkt_count     <= pkt_count_inc;
              seq           <= seq + CNT_WIDTH'(1);
              port          <= next_port(port, mask8_lat, NUM_PORTS);
              sweep_len     <= len_next;
              if (finish) begin
                state <= ST_DONE;
              end else if (gap_lat != 8'd0) begin
                state   <= ST_GAP;
                gap_cnt <= gap_lat;
              end else begin
                state <= ST_LOAD;
              end
            end else begin
              beat_idx     <= next_beat;
              m_axis_tdata <= data_next;
              m_axis_tlast <= next_is_last;
              m_axis_tkeep <= next_is_last ? keep_last : '1;
            end
          end
        end

        ST_GAP: begin
          if (stop) begin
            state <= ST_DONE;
          end else if (gap_cnt <= 8'd1) begin
            state <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nf10_upb_axis_pkt_gen.sv
// Directed self-checking bench for nf10_upb_axis_pkt_gen (default build, pattern payload).
// Each task drives one scenario and checks hand-derived expectations inline.
module tb_nf10_upb_axis_pkt_gen;

  localparam int DW = 256;
  localparam int LW = 14;
  localparam int NP = 5;
  localparam int CW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [CW-1:0] cfg_num_packets;
  logic [LW-1:0] cfg_len_min, cfg_len_max, cfg_len_step;
  logic          cfg_sweep;
  logic [NP-1:0] cfg_port_mask;
  logic [7:0]    cfg_gap;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [2:0]    m_axis_tuser_in_port;
  logic [LW-1:0] m_axis_tuser_packet_length;
  logic          busy, done;
  logic [CW-1:0] pkt_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nf10_upb_axis_pkt_gen #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .NUM_PORTS(NP), .CNT_WIDTH(CW)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .start                      (start),
    .stop                       (stop),
    .cfg_num_packets            (cfg_num_packets),
    .cfg_len_min                (cfg_len_min),
    .cfg_len_max                (cfg_len_max),
    .cfg_len_step               (cfg_len_step),
    .cfg_sweep                  (cfg_sweep),
    .cfg_port_mask              (cfg_port_mask),
    .cfg_gap                    (cfg_gap),
    .m_axis_tdata               (m_axis_tdata),
    .m_axis_tkeep               (m_axis_tkeep),
    .m_axis_tvalid              (m_axis_tvalid),
    .m_axis_tlast               (m_axis_tlast),
    .m_axis_tready              (m_axis_tready),
    .m_axis_tuser_in_port       (m_axis_tuser_in_port),
    .m_axis_tuser_packet_length (m_axis_tuser_packet_length),
    .busy                       (busy),
    .done                       (done),
    .pkt_count                  (pkt_count)
  );

  // Captured beats (one entry per handshake) and idle cycles preceding each beat.
  logic [DW-1:0] q_dat[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];
  logic [2:0]    q_port[$];
  logic [LW-1:0] q_len[$];
  int            q_idle[$];

  function automatic logic [DW-1:0] exp_dat(input int s, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = {16'(s), 12'(b), 4'(i)};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cfg(input int num, input int lmin, input int lmax, input int lstep,
                         input bit sweep, input int mask, input int gap);
    cfg_num_packets = CW'(num);
    cfg_len_min     = LW'(lmin);
    cfg_len_max     = LW'(lmax);
    cfg_len_step    = LW'(lstep);
    cfg_sweep       = sweep;
    cfg_port_mask   = NP'(mask);
    cfg_gap         = 8'(gap);
  endtask

  // Records beats until done is seen; timeout stays 1 if the budget runs out.
  task automatic collect(input int max_cyc, output bit timeout);
    int idle;
    idle = 0;
    timeout = 1'b1;
    q_dat.delete(); q_keep.delete(); q_last.delete();
    q_port.delete(); q_len.delete(); q_idle.delete();
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        q_dat.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_last.push_back(m_axis_tlast);
        q_port.push_back(m_axis_tuser_in_port);
        q_len.push_back(m_axis_tuser_packet_length);
        q_idle.push_back(idle);
        idle = 0;
      end else if (!m_axis_tvalid) begin
        idle++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0000 || m_axis_tdata !== '0 ||
        m_axis_tkeep !== '0 || pkt_count !== '0 || m_axis_tuser_in_port !== 3'd0 ||
        m_axis_tuser_packet_length !== '0) begin
      bad++;
      $display("FAIL reset_outputs: vld/last/busy/done=%b%b%b%b cnt=%0d keep=%h want all zero",
               m_axis_tvalid, m_axis_tlast, busy, done, pkt_count, m_axis_tkeep);
    end
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mask_zero();
    set_cfg(1, 64, 100, 0, 0, 0, 0);
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      total++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL mask_zero_start cyc%0d: busy=%b vld=%b done=%b want 0 0 0",
                 c, busy, m_axis_tvalid, done);
      end
      tick();
    end
  endtask

  task automatic test_fixed();
    bit to;
    set_cfg(3, 64, 100, 0, 0, 5'b00001, 0);
    pulse_start();
    total++;
    if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL fixed_load_cycle: busy=%b vld=%b want 1 0", busy, m_axis_tvalid);
    end
    collect(100, to);
    total++;
    if (to !== 1'b0 || q_dat.size() != 6) begin
      bad++;
      $display("FAIL fixed_beats: timeout=%b beats=%0d want 0 6", to, q_dat.size());
    end
    for (int k = 0; k < 6 && k < q_dat.size(); k++) begin
      total++;
      if (q_dat[k] !== exp_dat(k / 2, k % 2) || q_keep[k] !== {KW{1'b1}} ||
          q_last[k] !== 1'(k % 2) || q_port[k] !== 3'd0 || q_len[k] !== LW'(64)) begin
        bad++;
        $display("FAIL fixed_beat%0d: dat=%h keep=%h last=%b port=%0d len=%0d want dat=%h keep=all-ones last=%0d port=0 len=64",
                 k, q_dat[k], q_keep[k], q_last[k], q_port[k], q_len[k], exp_dat(k / 2, k % 2), k % 2);
      end
      if (k % 2 == 0) begin
        total++;
        if (q_idle[k] != 1) begin
          bad++;
          $display("FAIL fixed_spacing beat%0d: idle=%0d want 1", k, q_idle[k]);
        end
      end
    end
    total++;
    if (pkt_count !== 32'd3 || done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL fixed_end: cnt=%0d done=%b busy=%b vld=%b want 3 1 0 0",
               pkt_count, done, busy, m_axis_tvalid);
    end
  endtask

  task automatic test_sweep();
    bit to;
    int exp_len[3]   = '{42, 72, 42};
    int exp_port[3]  = '{1, 2, 1};
    int exp_beats[3] = '{2, 3, 2};
    logic [KW-1:0] exp_lk[3] = '{32'h0000_03FF, 32'h0000_00FF, 32'h0000_03FF};
    int idx;
    set_cfg(3, 42, 100, 30, 1, 5'b00110, 0);
    pulse_start();
    collect(100, to);
    total++;
    if (to !== 1'b0 || q_dat.size() != 7) begin
      bad++;
      $display("FAIL sweep_beats: timeout=%b beats=%0d want 0 7", to, q_dat.size());
    end
    idx = 0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < exp_beats[p]; b++) begin
        if (idx < q_dat.size()) begin
          total++;
          if (q_dat[idx] !== exp_dat(p, b) || q_len[idx] !== LW'(exp_len[p]) ||
              q_port[idx] !== 3'(exp_port[p]) || q_last[idx] !== (b == exp_beats[p] - 1) ||
              q_keep[idx] !== ((b == exp_beats[p] - 1) ? exp_lk[p] : {KW{1'b1}})) begin
            bad++;
            $display("FAIL sweep_pkt%0d_beat%0d: len=%0d port=%0d last=%b keep=%h want len=%0d port=%0d keep_last=%h",
                     p, b, q_len[idx], q_port[idx], q_last[idx], q_keep[idx],
                     exp_len[p], exp_port[p], exp_lk[p]);
          end
        end
        idx++;
      end
    end
  endtask

  task automatic test_backpressure();
    int beats, stall_left, last_at;
    bit stalled, to;
    logic [DW+KW+1+3+LW-1:0] snap;
    set_cfg(1, 224, 300, 0, 0, 5'b00001, 0);
    pulse_start();
    beats = 0; stall_left = 0; last_at = 0; stalled = 1'b0; to = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (stall_left > 0) begin
        total++;
        if (m_axis_tvalid !== 1'b1 ||
            {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_in_port,
             m_axis_tuser_packet_length} !== snap) begin
          bad++;
          $display("FAIL stall_hold left=%0d: vld=%b dat=%h want vld=1 dat=%h",
                   stall_left, m_axis_tvalid, m_axis_tdata, snap[DW+KW+1+3+LW-1 -: DW]);
        end
        stall_left--;
        if (stall_left == 0) m_axis_tready = 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (beats == 2 && !stalled) begin
          stalled = 1'b1;
          snap = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser_in_port,
                  m_axis_tuser_packet_length};
          m_axis_tready = 1'b0;
          stall_left = 6;
        end else begin
          total++;
          if (m_axis_tdata !== exp_dat(0, beats) || m_axis_tkeep !== {KW{1'b1}}) begin
            bad++;
            $display("FAIL bp_beat%0d: dat=%h keep=%h want dat=%h keep=all-ones",
                     beats, m_axis_tdata, m_axis_tkeep, exp_dat(0, beats));
          end
          beats++;
          if (m_axis_tlast && last_at == 0) last_at = beats;
        end
      end
      tick();
    end
    m_axis_tready = 1'b1;
    total++;
    if (to !== 1'b0 || beats != 7 || last_at != 7 || pkt_count !== 32'd1) begin
      bad++;
      $display("FAIL bp_totals: timeout=%b beats=%0d last_at=%0d cnt=%0d want 0 7 7 1",
               to, beats, last_at, pkt_count);
    end
  endtask

  task automatic test_stop();
    int beats, last_at, vcount;
    bit to;
    set_cfg(0, 224, 300, 0, 0, 5'b00001, 0);
    pulse_start();
    beats = 0; last_at = 0; to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (beats == 2) stop = 1'b1;
        if (m_axis_tlast && last_at == 0) last_at = beats + 1;
        beats++;
      end
      tick();
    end
    total++;
    if (to !== 1'b0 || beats != 7 || last_at != 7 || pkt_count !== 32'd1) begin
      bad++;
      $display("FAIL stop_completes: timeout=%b beats=%0d last_at=%0d cnt=%0d want 0 7 7 1",
               to, beats, last_at, pkt_count);
    end
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid) vcount++;
      tick();
    end
    total++;
    if (vcount != 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL stop_quiet: valid_cycles=%0d done=%b want 0 1", vcount, done);
    end
    stop = 1'b0;
  endtask

  task automatic test_gap_reset();
    int pkt, b, idle, seen_gap;
    bit hit, found;
    set_cfg(0, 128, 200, 0, 0, 5'b00001, 3);
    pulse_start();
    pkt = 0; b = 0; idle = 0; seen_gap = -1; hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (pkt == 1 && b == 0) seen_gap = idle;
        if (pkt == 1 && b == 2) begin
          reset = 1'b1;
          hit = 1'b1;
          break;
        end
        idle = 0;
        if (m_axis_tlast) begin
          pkt++;
          b = 0;
        end else begin
          b++;
        end
      end else if (!m_axis_tvalid) begin
        idle++;
      end
      tick();
    end
    total++;
    if (hit !== 1'b1 || seen_gap != 4) begin
      bad++;
      $display("FAIL gap_spacing: reached=%b idle=%0d want 1 4", hit, seen_gap);
    end
    tick();
    total++;
    if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0000 || m_axis_tdata !== '0 ||
        m_axis_tkeep !== '0 || pkt_count !== '0 || m_axis_tuser_packet_length !== '0) begin
      bad++;
      $display("FAIL reset_mid_packet: vld/last/busy/done=%b%b%b%b cnt=%0d want all zero",
               m_axis_tvalid, m_axis_tlast, busy, done, pkt_count);
    end
    reset = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (m_axis_tvalid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (found !== 1'b1 || m_axis_tdata !== exp_dat(0, 0) || m_axis_tuser_packet_length !== LW'(128)) begin
      bad++;
      $display("FAIL restart_seq0: found=%b dat=%h len=%0d want 1 %h 128",
               found, m_axis_tdata, m_axis_tuser_packet_length, exp_dat(0, 0));
    end
    stop = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    stop = 1'b0;
    total++;
    if (found !== 1'b1 || pkt_count !== 32'd1) begin
      bad++;
      $display("FAIL restart_stop: done_seen=%b cnt=%0d want 1 1", found, pkt_count);
    end
  endtask

  task automatic test_len_zero();
    bit to;
    set_cfg(1, 0, 100, 0, 0, 5'b00001, 0);
    pulse_start();
    collect(50, to);
    total++;
    if (to !== 1'b0 || q_dat.size() != 1) begin
      bad++;
      $display("FAIL len0_beats: timeout=%b beats=%0d want 0 1", to, q_dat.size());
    end
    if (q_dat.size() > 0) begin
      total++;
      if (q_keep[0] !== 32'h0000_0001 || q_last[0] !== 1'b1 || q_len[0] !== LW'(1) ||
          q_dat[0] !== exp_dat(0, 0)) begin
        bad++;
        $display("FAIL len0_beat: keep=%h last=%b len=%0d want 00000001 1 1",
                 q_keep[0], q_last[0], q_len[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    m_axis_tready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_mask_zero();
    test_fixed();
    test_sweep();
    test_backpressure();
    test_stop();
    test_gap_reset();
    test_len_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
